// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared defaults, entry record and saturating-increment helper
package bp_pkg;

  localparam int PC_W_DEFAULT  = 8;
  localparam int CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic [PC_W_DEFAULT-1:0] pc;
    logic                    taken;
  } bp_entry_t;

  // Increments v, but holds at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_fifo.sv
// rtl/bp_fifo.sv - circular prediction buffer with push, pop and flush
module bp_fifo
  import bp_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = bp_entry_t,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  entry_t      wdata,
  output entry_t      rdata,
  output logic        empty,
  output logic        full,
  output logic [AW:0] count
);

  entry_t          mem [DEPTH];
  logic   [AW-1:0] head;
  logic   [AW-1:0] tail;
  logic            push_eff;

  // A flush drops everything, including anything pushed in the same cycle.
  assign push_eff = push && !flush;

  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[tail] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_eff) begin
        tail <= tail + 1'b1;
      end
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (pop) begin
          head <= head + 1'b1;
        end
        count <= count + (AW+1)'(push_eff) - (AW+1)'(pop);
      end
    end
  end

  assign rdata = mem[head];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order prediction tracking, resolve compare and predictor feedback
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             fb_valid,
  output logic             fb_taken,
  output logic             mispredict,
  output logic [PC_W-1:0]  mispredict_pc,
  output logic             err_orphan,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] resolved_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
  } entry_t;

  entry_t      head_e;
  entry_t      new_e;
  logic [AW:0] occupancy;
  logic        res_acc;
  logic        is_miss;
  logic        push_acc;

  assign pred_ready = !full;
  assign new_e      = '{pc: pred_pc, taken: pred_taken};
  assign res_acc    = res_valid && (occupancy != '0);
  assign is_miss    = res_acc && (head_e.taken != res_taken);
  assign push_acc   = pred_valid && pred_ready;

  bp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_acc),
    .pop   (res_acc && !is_miss),
    .flush (is_miss),
    .wdata (new_e),
    .rdata (head_e),
    .empty (empty),
    .full  (full),
    .count (occupancy)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_valid      <= 1'b0;
      fb_taken      <= 1'b0;
      mispredict    <= 1'b0;
      mispredict_pc <= '0;
      err_orphan    <= 1'b0;
      resolved_cnt  <= '0;
      miss_cnt      <= '0;
    end else begin
      fb_valid   <= res_acc;
      fb_taken   <= res_acc && res_taken;
      mispredict <= is_miss;
      err_orphan <= res_valid && (occupancy == '0);
      if (res_acc) begin
        resolved_cnt <= CNT_W'(sat_inc(32'(resolved_cnt), CNT_W));
      end
      if (is_miss) begin
        mispredict_pc <= head_e.pc;
        miss_cnt      <= CNT_W'(sat_inc(32'(miss_cnt), CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - randomized self-checking bench for branch_resolve_queue
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 8;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
  logic [PC_W-1:0] pred_pc = '0;

  logic pred_ready, fb_valid, fb_taken, mispredict, err_orphan, empty, full;
  logic [PC_W-1:0]  mispredict_pc;
  logic [CNT_W-1:0] resolved_cnt, miss_cnt;

  logic pred_ready2, fb_valid2, fb_taken2, mispredict2, err_orphan2, empty2, full2;
  logic [PC_W-1:0] mispredict_pc2;
  logic [1:0]      resolved_cnt2, miss_cnt2;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken), .fb_valid(fb_valid),
    .fb_taken(fb_taken), .mispredict(mispredict), .mispredict_pc(mispredict_pc),
    .err_orphan(err_orphan), .empty(empty), .full(full), .resolved_cnt(resolved_cnt),
    .miss_cnt(miss_cnt)
  );

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_ready(pred_ready2), .res_valid(res_valid), .res_taken(res_taken), .fb_valid(fb_valid2),
    .fb_taken(fb_taken2), .mispredict(mispredict2), .mispredict_pc(mispredict_pc2),
    .err_orphan(err_orphan2), .empty(empty2), .full(full2), .resolved_cnt(resolved_cnt2),
    .miss_cnt(miss_cnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            taken;
  } m_t;

  m_t q[$];
  bit e_fbv, e_fbt, e_mis, e_orph, started;
  logic [PC_W-1:0] e_mpc;
  int e_res, e_miss, e_res2, e_miss2;

  initial begin
    started = 0; e_fbv = 0; e_fbt = 0; e_mis = 0; e_orph = 0; e_mpc = '0;
    e_res = 0; e_miss = 0; e_res2 = 0; e_miss2 = 0;
  end

  always @(posedge clk) begin : model
    int  sz;
    bit  acc, miss;
    m_t  h;
    sz = q.size();
    if (rst) begin
      q.delete();
      e_fbv = 0; e_fbt = 0; e_mis = 0; e_orph = 0; e_mpc = '0;
      e_res = 0; e_miss = 0; e_res2 = 0; e_miss2 = 0;
      started = 1;
    end else begin
      acc    = res_valid && (sz > 0);
      miss   = 0;
      e_fbv  = acc;
      e_fbt  = acc && res_taken;
      e_orph = res_valid && (sz == 0);
      if (acc) begin
        h    = q[0];
        miss = (h.taken != res_taken);
        if (e_res < CMAX) e_res++;
        if (e_res2 < 3) e_res2++;
        if (miss) begin
          e_mpc = h.pc;
          if (e_miss < CMAX) e_miss++;
          if (e_miss2 < 3) e_miss2++;
          q.delete();
        end else begin
          void'(q.pop_front());
        end
      end
      e_mis = miss;
      if (pred_valid && (sz < DEPTH) && !miss) q.push_back('{pred_pc, pred_taken});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("pred_ready", pred_ready, q.size() < DEPTH);
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == DEPTH);
      check("fb_valid", fb_valid, e_fbv);
      check("fb_taken", fb_taken, e_fbt);
      check("mispredict", mispredict, e_mis);
      check("mispredict_pc", mispredict_pc, e_mpc);
      check("err_orphan", err_orphan, e_orph);
      check("resolved_cnt", resolved_cnt, e_res);
      check("miss_cnt", miss_cnt, e_miss);
      check("resolved_cnt_w2", resolved_cnt2, e_res2);
      check("miss_cnt_w2", miss_cnt2, e_miss2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic t);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = t;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic t);
    res_valid = 1'b1; res_taken = t;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_ready", pred_ready, 1);
    check("rst_full", full, 0);
    check("rst_cnt", resolved_cnt, 0);

    push(8'h10, 1'b1); push(8'h14, 1'b0);
    resolve(1'b1);
    check("t1_fbv0", fb_valid, 1);
    check("t1_fbt0", fb_taken, 1);
    resolve(1'b0);
    check("t1_fbv1", fb_valid, 1);
    check("t1_fbt1", fb_taken, 0);
    check("t1_mis", mispredict, 0);
    tick();
    check("t1_fbv_off", fb_valid, 0);
    check("t1_res", resolved_cnt, 2);
    check("t1_miss", miss_cnt, 0);
    check("t1_empty", empty, 1);

    push(8'h20, 1'b1); push(8'h24, 1'b1); push(8'h28, 1'b0);
    resolve(1'b0);
    check("t2_mis", mispredict, 1);
    check("t2_mpc", mispredict_pc, 8'h20);
    check("t2_miss", miss_cnt, 1);
    check("t2_empty", empty, 1);
    tick();
    check("t2_mis_off", mispredict, 0);
    check("t2_mpc_hold", mispredict_pc, 8'h20);

    push(8'h40, 1'b1); push(8'h41, 1'b0); push(8'h42, 1'b1); push(8'h43, 1'b0);
    check("t3_full", full, 1);
    check("t3_ready", pred_ready, 0);
    push(8'h50, 1'b1);
    check("t3_full_still", full, 1);
    resolve(1'b1); resolve(1'b0); resolve(1'b1); resolve(1'b0);
    check("t3_mis", mispredict, 0);
    check("t3_empty", empty, 1);
    check("t3_res", resolved_cnt, 7);
    check("t3_sat2", resolved_cnt2, 3);
    push(8'h44, 1'b0); push(8'h45, 1'b1); push(8'h46, 1'b1);
    resolve(1'b0); resolve(1'b1); resolve(1'b1);
    check("t3_refill_res", resolved_cnt, 10);
    check("t3_refill_miss", miss_cnt, 1);

    resolve(1'b1);
    check("t4_orphan", err_orphan, 1);
    check("t4_fbv", fb_valid, 0);
    check("t4_res", resolved_cnt, 10);
    tick();
    check("t4_orphan_off", err_orphan, 0);

    push(8'h60, 1'b1); push(8'h64, 1'b1);
    pred_valid = 1'b1; pred_pc = 8'h30; pred_taken = 1'b1;
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    check("t5_empty", empty, 1);
    check("t5_mpc", mispredict_pc, 8'h60);
    check("t5_miss", miss_cnt, 2);
    resolve(1'b1);
    check("t5_no_fb", fb_valid, 0);
    check("t5_orphan", err_orphan, 1);

    push(8'h70, 1'b1); push(8'h74, 1'b0); push(8'h78, 1'b1);
    rst = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
    tick();
    rst = 1'b0; res_valid = 1'b0;
    check("t6_fbv", fb_valid, 0);
    check("t6_res", resolved_cnt, 0);
    check("t6_miss", miss_cnt, 0);
    check("t6_mpc", mispredict_pc, 0);
    check("t6_empty", empty, 1);
    check("t6_res2", resolved_cnt2, 0);

    for (int i = 0; i < 3000; i++) begin
      pred_valid = ($urandom_range(0, 99) < 55);
      pred_taken = $urandom_range(0, 1);
      pred_pc    = PC_W'($urandom);
      res_valid  = ($urandom_range(0, 99) < 45);
      if (q.size() > 0 && $urandom_range(0, 99) < 80) res_taken = q[0].taken;
      else res_taken = $urandom_range(0, 1);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    pred_valid = 1'b0; res_valid = 1'b0; rst = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits between fetch-side prediction and execute-side branch resolution. It feeds the 2-bit saturating-counter predictor's request/taken feedback inputs.
- Buffers each issued prediction (PC plus predicted direction) in an in-order queue until the branch resolves.
- On resolution it compares the actual outcome with the stored prediction. It emits a one-cycle feedback strobe to the predictor and a mispredict/flush pulse to fetch.
- Keeps saturating accuracy counters.

Parameters:
- DEPTH, 4, number of outstanding predictions; power of two, at least 2
- PC_W, 8, width of the branch PC tag stored per entry
- CNT_W, 16, width of the resolved-count and mispredict-count statistics counters

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- pred_valid  input  1  a prediction is being issued this cycle
- pred_taken  input  1  predicted direction (1 = taken)
- pred_pc  input  PC_W  PC tag of the predicted branch
- pred_ready  output  1  queue can accept a prediction; equals !full, combinational from occupancy
- res_valid  input  1  the oldest outstanding branch resolves this cycle
- res_taken  input  1  actual branch direction
- fb_valid  output  1  registered one-cycle strobe to the predictor's request input
- fb_taken  output  1  registered actual direction to the predictor's taken input
- mispredict  output  1  registered one-cycle pulse; prediction differed from outcome
- mispredict_pc  output  PC_W  PC tag of the mispredicted branch; holds its value until the next mispredict
- err_orphan  output  1  registered one-cycle pulse; res_valid arrived while the queue was empty
- empty  output  1  occupancy == 0
- full  output  1  occupancy == DEPTH
- resolved_cnt  output  CNT_W  total accepted resolutions, saturating at all-ones
- miss_cnt  output  CNT_W  total mispredicts, saturating at all-ones

Behaviour:
- Reset (rst high at a clock edge) has priority over all other activity:
  - pointers = 0, occupancy = 0, so empty = 1, full = 0, pred_ready = 1
  - fb_valid, fb_taken, mispredict, err_orphan = 0
  - mispredict_pc = 0, resolved_cnt = 0, miss_cnt = 0
  - a push or resolve in the same cycle as reset is discarded
- Storage is a circular buffer with head/tail pointers of width log2(DEPTH) that wrap modulo DEPTH, and an occupancy counter of width log2(DEPTH)+1. Each entry holds {pc, taken}.
- Push: accepted iff pred_valid && pred_ready. The entry is written at tail, tail advances, and occupancy increments. pred_valid while full is ignored: no write, no error.
- Resolve: accepted iff res_valid && !empty.
  - The head entry is compared with res_taken.
  - Next cycle: fb_valid = 1, fb_taken = res_taken, and mispredict = (head.taken != res_taken).
  - On a mispredict, mispredict_pc is loaded with head.pc.
  - Latency from resolve to feedback/mispredict is exactly 1 cycle.
  - resolved_cnt increments by 1, saturating. miss_cnt increments on a mispredict, saturating.
- Resolve, correct prediction: head advances and occupancy decrements.
- Resolve, mispredict: the queue is flushed. head = tail, occupancy = 0 next cycle, and all younger entries are dropped.
- Orphan: res_valid && empty produces err_orphan = 1 next cycle. There is no feedback and no counter change.
- Simultaneous push and correct-prediction resolve: both take effect and occupancy is unchanged. When full, pred_ready = 0, so no push occurs even if a pop happens the same cycle.
- Simultaneous push and mispredict resolve: the push is discarded, since it is a wrong-path instruction. Queue is empty next cycle.
- Simultaneous push and orphan resolve on an empty queue: the push is accepted, the orphan is flagged, and occupancy becomes 1.
- Outputs fb_valid, mispredict and err_orphan are high for exactly one cycle per event. They are 0 in all other cycles.
- There is no FSM beyond the pointer/occupancy state. Derive full and empty from occupancy, not from pointer equality.

Decomposition:
- Shared package bp_pkg: PC_W and CNT_W defaults, the entry record type {pc, taken}, and the saturate-increment helper function.
- One natural sub-module: bp_fifo, the circular-buffer storage with push, pop and flush inputs and empty/full/occupancy outputs.
- Compare, feedback registers and statistics counters stay in the top level.

Test Plan:
1. Reset, then push PCs 0x10 (taken=1) and 0x14 (taken=0), resolve 1 then 0 on consecutive cycles:
   - fb_valid high on two consecutive cycles with fb_taken 1 then 0
   - mispredict never high; resolved_cnt = 2, miss_cnt = 0; empty = 1 afterwards
2. Push 0x20/1, 0x24/1, 0x28/0, then resolve with res_taken = 0:
   - next cycle mispredict = 1, mispredict_pc = 0x20, miss_cnt = 1
   - occupancy 0 and empty = 1 on the following cycle
3. Fill with DEPTH = 4 pushes:
   - full = 1 and pred_ready = 0
   - a 5th pred_valid is ignored
   - four correct resolves return the entries in order, and pointers wrap cleanly on a refill
4. Assert res_valid while empty: err_orphan pulses for one cycle; fb_valid = 0 and counters unchanged.
5. With 2 entries queued, push 0x30 in the same cycle as a mispredict resolve: queue is empty next cycle, and 0x30 never produces feedback.
6. Assert rst mid-stream with 3 entries queued and a simultaneous resolve: all outputs and counters are 0 next cycle, and empty = 1. Also preload with CNT_W = 2 and check resolved_cnt saturates at 3.
